// File: rtl/direct_cache_if.sv
// Request/acknowledge bus for direct_cache: processor-side port plus the slowmem-side port.
interface direct_cache_if #(parameter int WORD_W = 16);
    logic              strobe;
    logic              rnotw;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              flush;
    logic              mfc;
    logic [WORD_W-1:0] rdata;
    logic              busy;
    logic              mem_strobe;
    logic              mem_rnotw;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_mfc;
    logic [WORD_W-1:0] mem_rdata;

    // Environment side: processor requests and slowmem responses.
    modport master (
        output strobe, rnotw, addr, wdata, flush, mem_mfc, mem_rdata,
        input  mfc, rdata, busy, mem_strobe, mem_rnotw, mem_addr, mem_wdata
    );

    modport slave (
        input  strobe, rnotw, addr, wdata, flush, mem_mfc, mem_rdata,
        output mfc, rdata, busy, mem_strobe, mem_rnotw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/direct_cache.sv
// Direct-mapped, one-word-line, write-through / no-write-allocate cache in front of slowmem.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module direct_cache #(
    parameter int CACHE_LINES = 8,
    parameter int INDEX_BITS  = 3,
    parameter int WORD_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    direct_cache_if.slave   bus
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]     hit_count,
    output logic [15:0]     miss_count
`endif
);
    localparam int TAG_W = WORD_W - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, WRITE} state_t;

    state_t                  state;
    logic [CACHE_LINES-1:0]  valid;
    logic [TAG_W-1:0]        tags [CACHE_LINES];
    logic [WORD_W-1:0]       data [CACHE_LINES];
    logic [WORD_W-1:0]       fill_addr;

    logic [INDEX_BITS-1:0]   idx;
    logic [TAG_W-1:0]        tag;
    logic [INDEX_BITS-1:0]   fill_idx;
    logic [TAG_W-1:0]        fill_tag;
    logic                    hit;

    assign idx      = bus.addr[INDEX_BITS-1:0];
    assign tag      = bus.addr[WORD_W-1:INDEX_BITS];
    assign fill_idx = fill_addr[INDEX_BITS-1:0];
    assign fill_tag = fill_addr[WORD_W-1:INDEX_BITS];
    assign hit      = valid[idx] && (tags[idx] == tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            valid          <= '0;
            fill_addr      <= '0;
            bus.mfc        <= 1'b0;
            bus.rdata      <= '0;
            bus.busy       <= 1'b0;
            bus.mem_strobe <= 1'b0;
            bus.mem_rnotw  <= 1'b1;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
`ifdef CACHE_STATS_EN
            hit_count      <= '0;
            miss_count     <= '0;
`endif
        end else begin
            bus.mfc <= 1'b0;
            case (state)
                IDLE: begin
                    // Flush takes priority; a simultaneous strobe is dropped.
                    if (bus.flush) begin
                        valid <= '0;
                    end else if (bus.strobe && bus.rnotw) begin
                        if (hit) begin
                            bus.rdata <= data[idx];
                            bus.mfc   <= 1'b1;
`ifdef CACHE_STATS_EN
                            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
`endif
                        end else begin
                            fill_addr      <= bus.addr;
                            bus.mem_strobe <= 1'b1;
                            bus.mem_rnotw  <= 1'b1;
                            bus.mem_addr   <= bus.addr;
                            bus.busy       <= 1'b1;
                            state          <= FILL_REQ;
`ifdef CACHE_STATS_EN
                            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
`endif
                        end
                    end else if (bus.strobe) begin
                        // Posted write: acknowledge now, slowmem sees a one-cycle strobe.
                        bus.mem_strobe <= 1'b1;
                        bus.mem_rnotw  <= 1'b0;
                        bus.mem_addr   <= bus.addr;
                        bus.mem_wdata  <= bus.wdata;
                        if (hit) data[idx] <= bus.wdata;
                        bus.mfc        <= 1'b1;
                        bus.busy       <= 1'b1;
                        state          <= WRITE;
                    end
                end
                FILL_REQ: begin
                    bus.mem_strobe <= 1'b0;
                    state          <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (bus.mem_mfc) begin
                        valid[fill_idx] <= 1'b1;
                        tags[fill_idx]  <= fill_tag;
                        data[fill_idx]  <= bus.mem_rdata;
                        bus.rdata       <= bus.mem_rdata;
                        bus.mfc         <= 1'b1;
                        bus.busy        <= 1'b0;
                        state           <= IDLE;
                    end
                end
                WRITE: begin
                    bus.mem_strobe <= 1'b0;
                    bus.mem_rnotw  <= 1'b1;
                    bus.busy       <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_direct_cache.sv
// Directed bench for direct_cache with a behavioural slowmem (MEMDELAY=4) that ignores cache reset.
module tb_direct_cache;
    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;

    direct_cache_if #(.WORD_W(16)) bus();

`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
    direct_cache dut (.clk(clk), .reset(reset), .bus(bus.slave),
                      .hit_count(hit_count), .miss_count(miss_count));
`else
    direct_cache dut (.clk(clk), .reset(reset), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    // slowmem: samples strobe, counts 4 edges, then pulses mfc for one cycle with the word.
    logic [15:0] smem [64];
    int          pend = 0;
    logic [5:0]  paddr = '0;
    always @(posedge clk) begin
        bus.mem_mfc <= 1'b0;
        if (mem_init) begin
            smem[5]  <= 16'h1234;
            smem[13] <= 16'hBEEF;
            smem[32] <= 16'h0000;
        end
        if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                bus.mem_mfc   <= 1'b1;
                bus.mem_rdata <= smem[paddr];
            end
        end
        if (bus.mem_strobe) begin
            if (bus.mem_rnotw) begin
                pend  <= 4;
                paddr <= bus.mem_addr[5:0];
            end else begin
                smem[bus.mem_addr[5:0]] <= bus.mem_wdata;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tg, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tg, obs, exp);
        end
    endtask

    task automatic read_hit(input logic [15:0] a, input logic [15:0] exp);
        bus.strobe = 1'b1; bus.rnotw = 1'b1; bus.addr = a;
        tick();
        bus.strobe = 1'b0;
        chk("hit_mfc", 16'(bus.mfc), 16'd1);
        chk("hit_rdata", bus.rdata, exp);
        chk("hit_no_mem_strobe", 16'(bus.mem_strobe), 16'd0);
        chk("hit_busy", 16'(bus.busy), 16'd0);
        tick();
        chk("hit_mfc_clear", 16'(bus.mfc), 16'd0);
    endtask

    // inj: cycle (1..5) in which a stray read strobe is presented while busy; 0 = none.
    task automatic read_miss(input logic [15:0] a, input logic [15:0] exp, input int inj);
        bus.strobe = 1'b1; bus.rnotw = 1'b1; bus.addr = a;
        tick();
        bus.strobe = 1'b0;
        chk("miss_mem_strobe", 16'(bus.mem_strobe), 16'd1);
        chk("miss_mem_rnotw", 16'(bus.mem_rnotw), 16'd1);
        chk("miss_mem_addr", bus.mem_addr, a);
        chk("miss_busy_e0", 16'(bus.busy), 16'd1);
        chk("miss_mfc_e0", 16'(bus.mfc), 16'd0);
        for (int k = 1; k <= 5; k++) begin
            bus.strobe = (k == inj);
            bus.addr   = 16'h0020;
            tick();
            chk("miss_wait_mem_strobe", 16'(bus.mem_strobe), 16'd0);
            chk("miss_wait_busy", 16'(bus.busy), 16'd1);
            chk("miss_wait_mfc", 16'(bus.mfc), 16'd0);
        end
        bus.strobe = 1'b0;
        tick();
        chk("miss_mfc_e6", 16'(bus.mfc), 16'd1);
        chk("miss_rdata", bus.rdata, exp);
        chk("miss_busy_e6", 16'(bus.busy), 16'd0);
        tick();
        chk("miss_mfc_clear", 16'(bus.mfc), 16'd0);
        chk("miss_no_extra_strobe", 16'(bus.mem_strobe), 16'd0);
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        bus.strobe = 1'b1; bus.rnotw = 1'b0; bus.addr = a; bus.wdata = d;
        tick();
        bus.strobe = 1'b0; bus.rnotw = 1'b1;
        chk("wr_mfc", 16'(bus.mfc), 16'd1);
        chk("wr_mem_strobe", 16'(bus.mem_strobe), 16'd1);
        chk("wr_mem_rnotw", 16'(bus.mem_rnotw), 16'd0);
        chk("wr_mem_addr", bus.mem_addr, a);
        chk("wr_mem_wdata", bus.mem_wdata, d);
        chk("wr_busy", 16'(bus.busy), 16'd1);
        tick();
        chk("wr2_mfc", 16'(bus.mfc), 16'd0);
        chk("wr2_mem_strobe", 16'(bus.mem_strobe), 16'd0);
        chk("wr2_mem_rnotw", 16'(bus.mem_rnotw), 16'd1);
        chk("wr2_busy", 16'(bus.busy), 16'd0);
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        bus.strobe = 1'b0; bus.rnotw = 1'b1; bus.addr = '0; bus.wdata = '0; bus.flush = 1'b0;
        tick();
        tick();
        chk("rst_mfc", 16'(bus.mfc), 16'd0);
        chk("rst_rdata", bus.rdata, 16'h0000);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_mem_strobe", 16'(bus.mem_strobe), 16'd0);
        chk("rst_mem_rnotw", 16'(bus.mem_rnotw), 16'd1);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
        reset = 1'b0; mem_init = 1'b0;
        tick();

        read_miss(16'h0005, 16'h1234, 0);
        read_hit(16'h0005, 16'h1234);
        read_miss(16'h000D, 16'hBEEF, 0);
        read_miss(16'h0005, 16'h1234, 0);

        write_word(16'h0005, 16'hAAAA);
        read_hit(16'h0005, 16'hAAAA);
        write_word(16'h0020, 16'h7777);
        read_miss(16'h0020, 16'h7777, 0);

        // Stray strobe during FILL_WAIT (its target 0020 would otherwise hit).
        read_miss(16'h000D, 16'hBEEF, 2);

        // Reset at E3 of a miss; slowmem still delivers a stale mfc afterwards.
        bus.strobe = 1'b1; bus.rnotw = 1'b1; bus.addr = 16'h0005;
        tick();
        bus.strobe = 1'b0;
        chk("abort_mem_strobe", 16'(bus.mem_strobe), 16'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_mfc", 16'(bus.mfc), 16'd0);
        chk("abort_mem_rnotw", 16'(bus.mem_rnotw), 16'd1);
        chk("abort_mem_addr", bus.mem_addr, 16'h0000);
        for (int k = 4; k <= 7; k++) begin
            tick();
            chk("stale_no_mfc", 16'(bus.mfc), 16'd0);
        end

        // Line 5 must be invalid, then hit, then flush (with a colliding strobe), then miss.
        read_miss(16'h0005, 16'hAAAA, 0);
        read_hit(16'h0005, 16'hAAAA);
        bus.flush = 1'b1; bus.strobe = 1'b1; bus.rnotw = 1'b1; bus.addr = 16'h0005;
        tick();
        bus.flush = 1'b0; bus.strobe = 1'b0;
        chk("flush_drop_mfc", 16'(bus.mfc), 16'd0);
        chk("flush_drop_mem_strobe", 16'(bus.mem_strobe), 16'd0);
        tick();
        read_miss(16'h0005, 16'hAAAA, 0);
`ifdef CACHE_STATS_EN
        chk("stats_hit", hit_count, 16'd1);
        chk("stats_miss", miss_count, 16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/direct_cache.md
Name: direct_cache

Overview:
Direct-mapped, one-word-per-line, write-through cache between the processor's memory port and slowmem. It presents the same request/acknowledge protocol upward (strobe, rnotw, addr, wdata to the cache; mfc, rdata back) and drives slowmem's strobe/rnotw/addr/wdata port downward. Read hits complete in one cycle; read misses fill from slowmem. All processes and instruction/data traffic share one cache.

Parameters:
CACHE_LINES, 8, number of lines; must equal 2**INDEX_BITS
INDEX_BITS, 3, line index width, taken from addr[INDEX_BITS-1:0]
WORD_W, 16, data/address word width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
strobe  in  1  request valid for one cycle; sampled only when busy=0
rnotw  in  1  1=read, 0=write
addr  in  16  word address
wdata  in  16  write data
flush  in  1  invalidate all lines; honoured only in IDLE
mfc  out  1  one-cycle completion pulse
rdata  out  16  read data; valid only while mfc=1
busy  out  1  1 while a fill or write is in flight
mem_strobe  out  1  to slowmem strobe
mem_rnotw  out  1  to slowmem rnotw
mem_addr  out  16  to slowmem addr
mem_wdata  out  16  to slowmem wdata
mem_mfc  in  1  from slowmem mfc
mem_rdata  in  16  from slowmem rdata

Behaviour:
- Storage: per line valid bit, tag = addr[15:INDEX_BITS], data word. Index = addr[INDEX_BITS-1:0].
- Reset, registered outputs: mfc=0, rdata=0, busy=0, mem_strobe=0, mem_rnotw=1, mem_addr=0, mem_wdata=0. All valid bits cleared; state=IDLE.
- States: IDLE, FILL_REQ, FILL_WAIT, WRITE.
- IDLE, strobe&rnotw, hit (valid & tag match): rdata<=line data, mfc<=1 at the same edge, so mfc is high in the cycle after the request. State stays IDLE.
- IDLE, strobe&rnotw, miss: latch addr; mem_strobe<=1, mem_rnotw<=1, mem_addr<=addr, busy<=1; go to FILL_REQ.
- FILL_REQ: mem_strobe<=0 (single-cycle strobe, so slowmem starts exactly one pend countdown); go to FILL_WAIT.
- FILL_WAIT, on mem_mfc=1:
  - write line (valid=1, tag, mem_rdata);
  - rdata<=mem_rdata, mfc<=1, busy<=0;
  - go to IDLE.
- Miss latency with MEMDELAY=4: request sampled at edge E0; mfc high in the cycle after E6.
- IDLE, strobe&!rnotw: write-through, no write-allocate.
  - mem_strobe<=1, mem_rnotw<=0, mem_addr<=addr, mem_wdata<=wdata.
  - On hit, line data<=wdata; on miss, cache state is unchanged.
  - mfc<=1 (posted write), busy<=1; go to WRITE.
- WRITE: mem_strobe<=0, mem_rnotw<=1, busy<=0; go to IDLE. Writes therefore occupy two cycles.
- mfc is high for exactly one cycle per accepted request; default mfc<=0.
- strobe while busy=1 is ignored (dropped); the requester holds off until busy=0.
- mem_mfc outside FILL_WAIT is ignored and never writes a line. This covers a stale fill after reset.
- flush in IDLE clears all valid bits at that edge. If strobe is also high in that cycle, the flush wins and the strobe is dropped.
- reset mid-fill or mid-write: the state, outputs and valid bits return to their reset values at that edge.

Optional Feature:
CACHE_STATS_EN. When defined, add outputs hit_count[15:0] and miss_count[15:0]:
- reset to 0;
- increment on each read hit / read miss acceptance;
- saturate at 16'hFFFF;
- writes are not counted;
- flush does not clear them.

When undefined, these ports and their counters do not exist, and all other behaviour is identical.

Test Plan:
- After reset, read addr 16'h0005 (slowmem m[5]=16'h1234): mem_strobe pulses one cycle with mem_addr=0005; mfc=1 with rdata=1234 in the cycle after E6; busy=1 from E0 through E5.
- Repeat read 0005: mfc=1, rdata=1234 in the cycle after the request; mem_strobe stays 0.
- Read 000D (same index 5, m[D]=16'hBEEF) evicts; read 0005 again: both miss with 6-edge latency; final rdata=1234.
- Write 0005<=16'hAAAA (hit), then read 0005: mem_strobe=1, mem_rnotw=0, mem_wdata=AAAA for one cycle; the read hits with rdata=AAAA. A write to uncached 0020 followed by a read of 0020 misses.
- Assert strobe during FILL_WAIT: no mem_strobe and no extra mfc. Assert reset at edge E3 of a miss: no mfc from that fill, and the stale mem_mfc at E5 leaves line 5 invalid, so the next read of 0005 misses.
- flush in IDLE after caching 0005, then read 0005: miss. With CACHE_STATS_EN defined, the whole sequence yields hit_count=1, miss_count=2 for read-0005, read-0005, flush, read-0005.
